addsub_sequencer: RTL and testbench

Sequencing controller for the 4-bit ripple adder/subtractor datapath (four full adders, XOR-on-B, ctrl as carry-in).
- Accepts operation requests over a valid/ready handshake and drives the datapath operand and ctrl inputs.
- Waits a programmable settle time for the ripple chain, then captures sum and carry.
- Returns the result over a second valid/ready handshake.
- Keeps a 4-bit accumulator so operations can be chained; its value feeds the seven-segment display path.

---
 rtl/addsub_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_addsub_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_sequencer.sv
// addsub_sequencer
// Sequencing controller for a 4-bit ripple adder/subtractor datapath.
// Accepts an operation over a valid/ready request handshake, drives the
// registered datapath operands, waits SETTLE_CYCLES for the ripple chain,
// then captures sum/carry/overflow and returns them over a result handshake.
// A 4-bit accumulator holds the last captured sum for chained operations and
// feeds the display path.
//
// Parameters:
//   SETTLE_CYCLES  cycles dp_* are held before capture (legal 1..15)
//
// Optional feature (compile-time macro ADDSUB_SELFCHECK_EN):
//   Adds output dp_err, a sticky flag that is set when the datapath result
//   captured does not match an internally computed reference sum.
//
// Ports:
//   clk, rst_n             clock (rising edge), async active-low reset
//   req_valid/req_ready    request handshake
//   req_op                 0 = A+B, 1 = A-B
//   req_acc                1 = accumulator replaces req_a as operand A
//   req_a, req_b           operands
//   acc_clr                accumulator clear, honoured in IDLE only
//   dp_a, dp_b, dp_ctrl    registered operands/mode to the datapath
//   dp_sum, dp_carry       datapath results
//   res_valid/res_ready    result handshake
//   res_sum, res_carry     captured result (carry 1 = no borrow in subtract)
//   res_ovf                signed two's-complement overflow
//   acc_value              accumulator contents
//   dp_err                 (ADDSUB_SELFCHECK_EN only) sticky datapath mismatch
module addsub_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_op,
    input  logic       req_acc,
    input  logic [3:0] req_a,
    input  logic [3:0] req_b,
    input  logic       acc_clr,
    output logic [3:0] dp_a,
    output logic [3:0] dp_b,
    output logic       dp_ctrl,
    input  logic [3:0] dp_sum,
    input  logic       dp_carry,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_sum,
    output logic       res_carry,
    output logic       res_ovf,
    output logic [3:0] acc_value
`ifdef ADDSUB_SELFCHECK_EN
    ,
    output logic       dp_err
`endif
);

    localparam int unsigned DW = 4;
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESULT = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;

    logic          accept_c;
    logic          capture_c;
    logic          clr_c;
    logic [DW-1:0] op_a_c;
    logic          ovf_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control strobes
    always_comb begin
        state_d   = state_q;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        clr_c     = 1'b0;
        case (state_q)
            IDLE: begin
                clr_c = acc_clr;
                // req_ready is low for the first IDLE cycle after reset
                if (req_valid && req_ready) begin
                    accept_c = 1'b1;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == CW'(0)) begin
                    capture_c = 1'b1;
                    state_d   = RESULT;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand A selection; a same-cycle clear makes the accumulator read as 0
    always_comb begin
        op_a_c = req_a;
        if (req_acc) begin
            op_a_c = acc_clr ? DW'(0) : acc_value;
        end
    end

    // Overflow: operands (after B inversion) share a sign that the sum lacks
    always_comb begin
        ovf_c = (dp_a[3] == (dp_b[3] ^ dp_ctrl)) && (dp_sum[3] != dp_a[3]);
    end

    // Handshake flags track the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_ready <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            req_ready <= (state_d == IDLE);
            res_valid <= (state_d == RESULT);
        end
    end

    // Datapath operands and settle counter; dp_* change only on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_a    <= DW'(0);
            dp_b    <= DW'(0);
            dp_ctrl <= 1'b0;
            cnt_q   <= CW'(0);
        end else if (accept_c) begin
            dp_a    <= op_a_c;
            dp_b    <= req_b;
            dp_ctrl <= req_op;
            cnt_q   <= CW'(SETTLE_CYCLES - 1);
        end else if ((state_q == SETTLE) && (cnt_q != CW'(0))) begin
            cnt_q   <= cnt_q - CW'(1);
        end
    end

    // Result capture and accumulator
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_sum   <= DW'(0);
            res_carry <= 1'b0;
            res_ovf   <= 1'b0;
            acc_value <= DW'(0);
        end else if (capture_c) begin
            res_sum   <= dp_sum;
            res_carry <= dp_carry;
            res_ovf   <= ovf_c;
            acc_value <= dp_sum;
        end else if (clr_c) begin
            acc_value <= DW'(0);
        end
    end

`ifdef ADDSUB_SELFCHECK_EN
    logic [DW:0] ref_sum_c;

    // Reference ripple result for the operands currently driven
    always_comb begin
        ref_sum_c = (DW+1)'(dp_a) + (DW+1)'(dp_b ^ {DW{dp_ctrl}}) + (DW+1)'(dp_ctrl);
    end

    // Sticky mismatch flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_err <= 1'b0;
        end else if (capture_c && ({dp_carry, dp_sum} != ref_sum_c)) begin
            dp_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_addsub_sequencer.sv
// Self-checking bench for addsub_sequencer with a behavioural ripple datapath
// and a scoreboard of expected results built from integer arithmetic.
module tb_addsub_sequencer;

    localparam int unsigned SETTLE = 2;

    typedef struct packed {
        logic [3:0] sum;
        logic       carry;
        logic       ovf;
        logic [3:0] acc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic       req_op;
    logic       req_acc;
    logic [3:0] req_a;
    logic [3:0] req_b;
    logic       acc_clr;
    logic [3:0] dp_a;
    logic [3:0] dp_b;
    logic       dp_ctrl;
    logic [3:0] dp_sum;
    logic       dp_carry;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_sum;
    logic       res_carry;
    logic       res_ovf;
    logic [3:0] acc_value;
`ifdef ADDSUB_SELFCHECK_EN
    logic       dp_err;
`endif

    logic       force_zero;
    logic [3:0] acc_model;
    exp_t       sb[$];
    int         n_checks;
    int         n_pass;

    addsub_sequencer #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_acc   (req_acc),
        .req_a     (req_a),
        .req_b     (req_b),
        .acc_clr   (acc_clr),
        .dp_a      (dp_a),
        .dp_b      (dp_b),
        .dp_ctrl   (dp_ctrl),
        .dp_sum    (dp_sum),
        .dp_carry  (dp_carry),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_carry (res_carry),
        .res_ovf   (res_ovf),
        .acc_value (acc_value)
`ifdef ADDSUB_SELFCHECK_EN
        ,
        .dp_err    (dp_err)
`endif
    );

    // Behavioural ripple adder/subtractor, with an optional stuck-at-zero fault
    always_comb begin
        if (force_zero) begin
            {dp_carry, dp_sum} = 5'd0;
        end else begin
            {dp_carry, dp_sum} = 5'(dp_a) + 5'(dp_b ^ {4{dp_ctrl}}) + 5'(dp_ctrl);
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation through both handshakes; hold = RESULT cycles with res_ready low
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic op,
                         input logic use_acc, input logic clr_now, input logic fault,
                         input int hold, input logic clr_in_res);
        int         n;
        int         ua;
        int         ub;
        int         sa;
        int         sbv;
        int         r;
        int         sr;
        logic [3:0] opa;
        exp_t       e;

        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_idle", 8'(req_ready), 8'd1);

        opa = use_acc ? (clr_now ? 4'd0 : acc_model) : a;
        ua  = int'(opa);
        ub  = int'(b);
        sa  = opa[3] ? ua - 16 : ua;
        sbv = b[3] ? ub - 16 : ub;
        if (op) begin
            r       = ua - ub;
            sr      = sa - sbv;
            e.carry = (ua >= ub);
        end else begin
            r       = ua + ub;
            sr      = sa + sbv;
            e.carry = (r > 15);
        end
        e.sum = 4'(r);
        e.ovf = (sr > 7) || (sr < -8);
        if (fault) begin
            // only used with small positive operands, so no overflow either way
            e.sum   = 4'd0;
            e.carry = 1'b0;
            e.ovf   = 1'b0;
        end
        e.acc     = e.sum;
        acc_model = e.sum;
        sb.push_back(e);

        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_acc   = use_acc;
        acc_clr   = clr_now;
        @(posedge clk); #1;
        req_valid = 1'b0;
        acc_clr   = 1'b0;
        force_zero = fault;
        check("dp_a", 8'(dp_a), 8'(opa));
        check("dp_b", 8'(dp_b), 8'(b));
        check("dp_ctrl", 8'(dp_ctrl), 8'(op));
        check("req_ready_busy", 8'(req_ready), 8'd0);

        n = 0;
        while (!res_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("latency", 8'(n), 8'(SETTLE));
        force_zero = 1'b0;

        for (int i = 0; i < hold; i++) begin
            res_ready = 1'b0;
            req_valid = 1'b1;
            req_a     = ~a;
            req_acc   = 1'b0;
            acc_clr   = clr_in_res;
            @(posedge clk); #1;
            check("hold_valid", 8'(res_valid), 8'd1);
            check("hold_sum", 8'(res_sum), 8'(sb[0].sum));
            check("hold_ready", 8'(req_ready), 8'd0);
            check("hold_dp_a", 8'(dp_a), 8'(opa));
            check("hold_acc", 8'(acc_value), 8'(sb[0].acc));
        end
        req_valid = 1'b0;
        acc_clr   = 1'b0;
        res_ready = 1'b1;

        if (sb.size() == 0) begin
            check("sb_empty", 8'd0, 8'd1);
        end else begin
            e = sb.pop_front();
            check("res_sum", 8'(res_sum), 8'(e.sum));
            check("res_carry", 8'(res_carry), 8'(e.carry));
            check("res_ovf", 8'(res_ovf), 8'(e.ovf));
            check("acc_value", 8'(acc_value), 8'(e.acc));
        end
        @(posedge clk); #1;
        res_ready = 1'b0;
        check("res_valid_drop", 8'(res_valid), 8'd0);
        check("req_ready_back", 8'(req_ready), 8'd1);
    endtask

    initial begin
        int seen;
        n_checks   = 0;
        n_pass     = 0;
        force_zero = 1'b0;
        acc_model  = 4'd0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 1'b0;
        req_acc    = 1'b0;
        req_a      = 4'd0;
        req_b      = 4'd0;
        acc_clr    = 1'b0;
        res_ready  = 1'b0;

        // Reset state
        #1;
        check("rst_req_ready", 8'(req_ready), 8'd0);
        check("rst_dp", 8'({dp_a, dp_b}), 8'd0);
        check("rst_res", 8'({res_valid, res_sum, res_carry, res_ovf}), 8'd0);
        check("rst_acc", 8'(acc_value), 8'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_ready", 8'(req_ready), 8'd1);

        // Add and subtract
        do_op(4'd3, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        do_op(4'd7, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        do_op(4'd2, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0);

        // Accumulator clear in IDLE, then chained accumulation
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr   = 1'b0;
        acc_model = 4'd0;
        check("acc_clr_idle", 8'(acc_value), 8'd0);
        do_op(4'd0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        do_op(4'd0, 4'd9, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0);

        // Backpressure with a pending request, then clear ignored in RESULT
        do_op(4'd1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 5, 1'b0);
        do_op(4'd4, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1'b1);

        // Clear coinciding with an accumulator-sourced accept reads A as 0
        do_op(4'd0, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b0);

        // Reset in the middle of SETTLE discards the operation
        req_valid = 1'b1;
        req_a     = 4'd4;
        req_b     = 4'd1;
        req_op    = 1'b0;
        req_acc   = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 8'(req_ready), 8'd0);
        check("mid_rst_dp", 8'({dp_a, dp_b}), 8'd0);
        check("mid_rst_res", 8'({res_valid, res_sum, res_carry, res_ovf}), 8'd0);
        check("mid_rst_acc", 8'(acc_value), 8'd0);
        acc_model = 4'd0;
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        check("no_res_after_rst", 8'(seen), 8'd0);
        check("ready_after_rst", 8'(req_ready), 8'd1);
        do_op(4'd6, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);

`ifdef ADDSUB_SELFCHECK_EN
        // Faulty datapath sets the sticky error flag
        check("dp_err_clean", 8'(dp_err), 8'd0);
        do_op(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0);
        check("dp_err_set", 8'(dp_err), 8'd1);
        do_op(4'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        check("dp_err_sticky", 8'(dp_err), 8'd1);
        rst_n = 1'b0;
        #1;
        check("dp_err_rst", 8'(dp_err), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
